ospfb_sequencer: RTL and testbench

OSPFB_SEQUENCER -- requirements
Module: ospfb_sequencer

---
 rtl/ospfb_sequencer.sv | 141 ++++++++++++++
 tb/tb_ospfb_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_sequencer.sv
// ---------------------------------------------------------------------------
// ospfb_sequencer
//
// Frame sequencer for an oversampled polyphase filter bank. Each frame is
// FFT_LEN (M) cycles long: the first DEC_FAC (D) cycles take a fresh ADC
// sample into the PE chain, and the remaining M-D cycles recirculate
// delay-line contents. Branch indices count down M-1..0 within a frame.
// At every frame wrap the phase-compensation rotation advances by D
// (mod M), and the ping-pong compensation buffer flips.
//
// Parameters:
//   FFT_LEN - polyphase branches M, a power of two, >= 4
//   DEC_FAC - decimation factor D, 0 < D < M
//
// Ports:
//   clk       - DSP clock
//   rst_n     - asynchronous active-low reset
//   s_valid   - ADC sample available
//   s_ready   - sample accepted this cycle
//   m_ready   - datapath can advance
//   m_en      - datapath shift enable (advance strobe)
//   m_din_sel - 1: new sample, 0: delay-line feedback
//   m_branch  - current polyphase branch index
//   m_rot     - phase-compensation rotation offset
//   m_phase   - compensation buffer being filled (FILLA/FILLB)
//   m_last    - last branch of the frame
//   err_ovf   - sticky dropped-sample flag
//
// Optional feature: define OSPFB_SEQ_OVF_CHECK_EN to build the sticky
// overflow detector; otherwise err_ovf is a constant 0.
// ---------------------------------------------------------------------------

package ospfb_sequencer_pkg;
  typedef enum logic {FILLA = 1'b0, FILLB = 1'b1} phasecomp_state_t;
endpackage

module ospfb_sequencer
  import ospfb_sequencer_pkg::*;
#(
  parameter int FFT_LEN = 64,
  parameter int DEC_FAC = 48,
  localparam int W = $clog2(FFT_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             m_ready,
  output logic             m_en,
  output logic             m_din_sel,
  output logic [W-1:0]     m_branch,
  output logic [W-1:0]     m_rot,
  output phasecomp_state_t m_phase,
  output logic             m_last,
  output logic             err_ovf
);

  localparam logic [W-1:0] DEC_W  = W'(DEC_FAC);
  localparam logic [W-1:0] LAST_W = W'(FFT_LEN - 1);
  localparam logic [W:0]   LEN_W1 = (W+1)'(FFT_LEN);

  logic [W-1:0]     cyc_q, cyc_d;
  logic [W-1:0]     rot_q, rot_d;
  phasecomp_state_t phase_q, phase_d;
  logic [W:0]       rot_sum;
  logic [W:0]       rot_red;
  logic             advance;

  // Frame decode from the cycle counter. Everything that leaves the block
  // is gated by rst_n so the datapath sees no strobes while held in reset.
  always_comb begin
    m_din_sel = (cyc_q < DEC_W);
    m_last    = (cyc_q == LAST_W);
    m_branch  = LAST_W - cyc_q;
    s_ready   = rst_n & m_ready & m_din_sel;
    advance   = rst_n & m_ready & (~m_din_sel | s_valid);
    m_en      = advance;
    m_rot     = rot_q;
    m_phase   = phase_q;
  end

  // Rotation update uses one extra bit so rot + D never wraps before the
  // single conditional subtract of M brings it back into range.
  always_comb begin
    rot_sum = {1'b0, rot_q} + {1'b0, DEC_W};
    rot_red = (rot_sum >= LEN_W1) ? (rot_sum - LEN_W1) : rot_sum;
  end

  // Next-state logic: nothing moves unless the datapath actually advances,
  // so an input stall or a back-pressured datapath freezes the frame.
  always_comb begin
    cyc_d   = cyc_q;
    rot_d   = rot_q;
    phase_d = phase_q;
    if (advance) begin
      if (m_last) begin
        cyc_d   = '0;
        rot_d   = rot_red[W-1:0];
        phase_d = (phase_q == FILLA) ? FILLB : FILLA;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  // Sequencer state register; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      rot_q   <= '0;
      phase_q <= FILLA;
    end else begin
      cyc_q   <= cyc_d;
      rot_q   <= rot_d;
      phase_q <= phase_d;
    end
  end

`ifdef OSPFB_SEQ_OVF_CHECK_EN
  logic err_ovf_q, err_ovf_d;

  // Sticky OR: a sample offered while not accepted is a lost sample, and
  // once seen the flag holds until reset.
  always_comb begin
    err_ovf_d = err_ovf_q | (s_valid & ~s_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
    end
  end

  assign err_ovf = err_ovf_q;
`else
  assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ospfb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ospfb_sequencer
//
// Directed bench for ospfb_sequencer at M=64, D=48. A short table of
// hand-computed vectors covers handshaking right after reset; hand-written
// sequences cover steady-state framing and rotation, input and output
// stalls, reset mid-frame and the sticky overflow flag (the latter only
// when OSPFB_SEQ_OVF_CHECK_EN is defined).
// ---------------------------------------------------------------------------

module tb_ospfb_sequencer;
  import ospfb_sequencer_pkg::*;

  localparam int M = 64;
  localparam int D = 48;
  localparam int W = 6;

`ifdef OSPFB_SEQ_OVF_CHECK_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic             m_ready;
  logic             m_en;
  logic             m_din_sel;
  logic [W-1:0]     m_branch;
  logic [W-1:0]     m_rot;
  phasecomp_state_t m_phase;
  logic             m_last;
  logic             err_ovf;

  int   checks   = 0;
  int   failures = 0;
  logic expErr   = 1'b0;

  typedef struct {
    logic             sv;
    logic             mr;
    logic [W-1:0]     branch;
    logic             din;
    logic             en;
    logic             last;
    logic [W-1:0]     rot;
    phasecomp_state_t phase;
  } vec_t;

  vec_t vecs[6];

  ospfb_sequencer #(.FFT_LEN(M), .DEC_FAC(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_ready   (m_ready),
    .m_en      (m_en),
    .m_din_sel (m_din_sel),
    .m_branch  (m_branch),
    .m_rot     (m_rot),
    .m_phase   (m_phase),
    .m_last    (m_last),
    .err_ovf   (err_ovf)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic mr);
    s_valid = sv;
    m_ready = mr;
  endtask

  // Checks all outputs mid-cycle, then steps one clock and updates the
  // expected overflow flag from what was offered during that cycle.
  task automatic checkOutput(input string name, input logic [W-1:0] branch, input logic din,
                             input logic en, input logic last, input logic [W-1:0] rot,
                             input phasecomp_state_t phase);
    logic expReady;
    expReady = m_ready & din;
    @(negedge clk);
    compare({name, ".branch"}, 32'(m_branch), 32'(branch));
    compare({name, ".din_sel"}, 32'(m_din_sel), 32'(din));
    compare({name, ".en"}, 32'(m_en), 32'(en));
    compare({name, ".s_ready"}, 32'(s_ready), 32'(expReady));
    compare({name, ".last"}, 32'(m_last), 32'(last));
    compare({name, ".rot"}, 32'(m_rot), 32'(rot));
    compare({name, ".phase"}, 32'(m_phase), 32'(phase));
    compare({name, ".err_ovf"}, 32'(err_ovf), 32'(expErr));
    @(posedge clk);
    #1;
    if (OVF_ON && s_valid && !expReady) expErr = 1'b1;
  endtask

  // Asserts reset away from the clock edge and checks the forced values
  // immediately, then releases just after the next rising edge.
  task automatic resetCheck(input string name);
    applyStimulus(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    expErr = 1'b0;
    compare({name, ".branch"}, 32'(m_branch), 32'(M - 1));
    compare({name, ".din_sel"}, 32'(m_din_sel), 32'd1);
    compare({name, ".last"}, 32'(m_last), 32'd0);
    compare({name, ".rot"}, 32'(m_rot), 32'd0);
    compare({name, ".phase"}, 32'(m_phase), 32'(FILLA));
    compare({name, ".en"}, 32'(m_en), 32'd0);
    compare({name, ".s_ready"}, 32'(s_ready), 32'd0);
    compare({name, ".err_ovf"}, 32'(err_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int f;
    int k;

    vecs[0] = '{1'b1, 1'b1, 6'd63, 1'b1, 1'b1, 1'b0, 6'd0, FILLA};
    vecs[1] = '{1'b0, 1'b1, 6'd62, 1'b1, 1'b0, 1'b0, 6'd0, FILLA};
    vecs[2] = '{1'b1, 1'b0, 6'd62, 1'b1, 1'b0, 1'b0, 6'd0, FILLA};
    vecs[3] = '{1'b1, 1'b1, 6'd62, 1'b1, 1'b1, 1'b0, 6'd0, FILLA};
    vecs[4] = '{1'b0, 1'b1, 6'd61, 1'b1, 1'b0, 1'b0, 6'd0, FILLA};
    vecs[5] = '{1'b1, 1'b1, 6'd61, 1'b1, 1'b1, 1'b0, 6'd0, FILLA};

    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1);
    #2;
    resetCheck("reset0");

    $display("[TB] handshake vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].mr);
      checkOutput($sformatf("vec%0d", i), vecs[i].branch, vecs[i].din, vecs[i].en,
                  vecs[i].last, vecs[i].rot, vecs[i].phase);
    end

    $display("[TB] steady state and rotation over 5 frames");
    resetCheck("reset1");
    for (int c = 0; c < 5 * M; c++) begin
      f = c / M;
      k = c % M;
      applyStimulus(1'b1, 1'b1);
      checkOutput("steady", 6'(M - 1 - k), k < D, 1'b1, k == M - 1,
                  6'((D * f) % M), (f % 2) ? FILLB : FILLA);
    end

    $display("[TB] input stall at cyc 10");
    resetCheck("reset2");
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("pre_in_stall", 6'(M - 1 - c), 1'b1, 1'b1, 1'b0, 6'd0, FILLA);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("in_stall", 6'd53, 1'b1, 1'b0, 1'b0, 6'd0, FILLA);
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("in_resume", 6'd53, 1'b1, 1'b1, 1'b0, 6'd0, FILLA);
    for (int c = 11; c < 50; c++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("to_out_stall", 6'(M - 1 - c), c < D, 1'b1, 1'b0, 6'd0, FILLA);
    end

    $display("[TB] output stall at cyc 50");
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("out_stall", 6'd13, 1'b0, 1'b0, 1'b0, 6'd0, FILLA);
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("out_resume", 6'd13, 1'b0, 1'b1, 1'b0, 6'd0, FILLA);

    for (int c = 51; c < 2 * M + 30; c++) begin
      f = c / M;
      k = c % M;
      applyStimulus(1'b1, 1'b1);
      checkOutput("to_mid_reset", 6'(M - 1 - k), k < D, 1'b1, k == M - 1,
                  6'((D * f) % M), (f % 2) ? FILLB : FILLA);
    end

    $display("[TB] reset mid-frame at frame 2 cyc 30");
    #2;
    compare("pre_reset.branch", 32'(m_branch), 32'd33);
    compare("pre_reset.rot", 32'(m_rot), 32'd32);
    resetCheck("reset_mid");
    applyStimulus(1'b1, 1'b1);
    checkOutput("post_reset0", 6'd63, 1'b1, 1'b1, 1'b0, 6'd0, FILLA);
    applyStimulus(1'b1, 1'b1);
    checkOutput("post_reset1", 6'd62, 1'b1, 1'b1, 1'b0, 6'd0, FILLA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
